// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative RV32M multiply/divide unit (MUL, MULH, MULHSU, MULHU,
//            DIV, DIVU, REM, REMU). One radix-2 step per clock: shift-add for
//            multiply, restoring subtract-shift for divide. The iteration runs
//            on operand magnitudes; signs are applied when the result is
//            registered. Divide-by-zero and signed overflow skip the iteration.
// Ports    : clk_i     clock, rising edge
//            rst_i     synchronous active-high reset
//            valid_i   request valid        ready_o   request accepted in IDLE
//            op_i      operation select     a_i/b_i   operands
//            valid_o   result valid         ready_i   result consumed
//            result_o  registered result    busy_o    high in CALC or DONE
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int              CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic                ready_q;
  logic                valid_q;
  logic                busy_q;
  logic [XLEN-1:0]     result_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          op_q;
  logic                a_neg_q;
  logic                b_neg_q;
  // acc_q: multiply -> {partial high, multiplier shifting out};
  //        divide   -> {remainder, dividend shifting out / quotient shifting in}
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opnd_q;   // multiplicand or divisor magnitude

  // Request decode
  logic                is_div_d;
  logic                a_neg_d;
  logic                b_neg_d;
  logic [XLEN-1:0]     mag_a_d;
  logic [XLEN-1:0]     mag_b_d;
  logic                special_d;
  logic [XLEN-1:0]     special_res_d;

  always_comb begin
    is_div_d = op_i[2];
    a_neg_d  = ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                (op_i == OP_DIV)  || (op_i == OP_REM)) && a_i[XLEN-1];
    b_neg_d  = ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM)) &&
               b_i[XLEN-1];
    // Negating the signed minimum wraps to itself, which is its correct
    // unsigned magnitude.
    mag_a_d  = a_neg_d ? (~a_i + 1'b1) : a_i;
    mag_b_d  = b_neg_d ? (~b_i + 1'b1) : b_i;

    special_d     = 1'b0;
    special_res_d = '0;
    if (is_div_d && (b_i == '0)) begin
      special_d     = 1'b1;
      special_res_d = op_i[1] ? a_i : '1;      // REM/REMU -> a, DIV/DIVU -> -1
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (a_i == SMIN) && (b_i == '1)) begin
      special_d     = 1'b1;
      special_res_d = op_i[1] ? '0 : SMIN;
    end
  end

  // One iteration step
  logic [XLEN:0]       mul_sum_d;
  logic [2*XLEN-1:0]   mul_next_d;
  logic [XLEN:0]       div_trial_d;
  logic                div_ge_d;
  logic [2*XLEN-1:0]   div_next_d;
  logic [2*XLEN-1:0]   step_d;

  always_comb begin
    mul_sum_d   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_next_d  = {mul_sum_d, acc_q[XLEN-1:1]};

    // The remainder stays below the divisor, so bit XLEN of the trial
    // difference is a clean borrow flag.
    div_trial_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    div_ge_d    = ~div_trial_d[XLEN];
    div_next_d  = {(div_ge_d ? div_trial_d[XLEN-1:0] : acc_q[2*XLEN-2:XLEN-1]),
                   acc_q[XLEN-2:0], div_ge_d};

    step_d      = op_q[2] ? div_next_d : mul_next_d;
  end

  // Sign fix-up applied on the final step
  logic [2*XLEN-1:0]   prod_fix_d;
  logic [XLEN-1:0]     quot_d;
  logic [XLEN-1:0]     rem_d;
  logic [XLEN-1:0]     final_d;

  always_comb begin
    prod_fix_d = (a_neg_q ^ b_neg_q) ? (~step_d + 1'b1) : step_d;
    quot_d     = step_d[XLEN-1:0];
    rem_d      = step_d[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:    final_d = prod_fix_d[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  final_d = prod_fix_d[2*XLEN-1:XLEN];
      OP_DIV:    final_d = (a_neg_q ^ b_neg_q) ? (~quot_d + 1'b1) : quot_d;
      OP_DIVU:   final_d = quot_d;
      OP_REM:    final_d = a_neg_q ? (~rem_d + 1'b1) : rem_d;
      OP_REMU:   final_d = rem_d;
      default:   final_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_i) begin
            op_q    <= op_i;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (special_d) begin
              result_q <= special_res_d;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= {{XLEN{1'b0}}, (is_div_d ? mag_a_d : mag_b_d)};
              opnd_q  <= is_div_d ? mag_b_d : mag_a_d;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= step_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            result_q <= final_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign result_o = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Purpose  : Self-checking bench for alu_muldiv (XLEN=32): vector table of
//            operations with hand-computed results and latencies, plus
//            backpressure and mid-operation reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive a request; returns #1 after the accepting edge t0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Counts edges after t0 until valid_o is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.op, v.a, v.b);
    check({v.name, " busy"}, 32'(busy_o), 32'd1);
    check({v.name, " ready"}, 32'(ready_o), 32'd0);
    wait_valid(lat);
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " result"}, result_o, v.exp);
    @(posedge clk);
    #1;
    check({v.name, " valid drop"}, 32'(valid_o), 32'd0);
    check({v.name, " result hold"}, result_o, v.exp);
  endtask

  vec_t vecs[19];

  initial begin
    int lat;
    vecs[0]  = '{"MUL 7*-3",          3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32};
    vecs[1]  = '{"MULH min*min",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32};
    vecs[2]  = '{"MULHU max*max",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    vecs[3]  = '{"MULHSU -1*2",       3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32};
    vecs[4]  = '{"MULHSU min*umax",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32};
    vecs[5]  = '{"DIV -7/2",          3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32};
    vecs[6]  = '{"REM -7/2",          3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32};
    vecs[7]  = '{"DIVU 100/7",        3'b101, 32'd100,      32'd7,        32'd14,       32};
    vecs[8]  = '{"REMU 100/7",        3'b111, 32'd100,      32'd7,        32'd2,        32};
    vecs[9]  = '{"DIV 7/-2",          3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32};
    vecs[10] = '{"REM 7/-2",          3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32};
    vecs[11] = '{"DIVU umax/1",       3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32};
    vecs[12] = '{"DIV min/2",         3'b100, 32'h80000000, 32'd2,        32'hC0000000, 32};
    vecs[13] = '{"DIVU 5/0",          3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    vecs[14] = '{"REM 5/0",           3'b110, 32'd5,        32'd0,        32'd5,        0};
    vecs[15] = '{"REMU 7/0",          3'b111, 32'd7,        32'd0,        32'd7,        0};
    vecs[16] = '{"DIV min/-1",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[17] = '{"REM min/-1",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
    vecs[18] = '{"MUL 3*5",           3'b000, 32'd3,        32'd5,        32'd15,       32};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 3'b000;
    a_i     = '0;
    b_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(ready_o), 32'd1);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset result", result_o, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(vecs[i]);

    // Backpressure: result must be held while ready_i is low, and a pending
    // request must not be taken until DONE has been left.
    ready_i = 1'b0;
    issue(3'b000, 32'd3, 32'd5);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'd32);
    op_i    = 3'b101;
    a_i     = 32'd9;
    b_i     = 32'd0;
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp valid held", 32'(valid_o), 32'd1);
      check("bp result held", result_o, 32'd15);
      check("bp ready low", 32'(ready_o), 32'd0);
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid", 32'(valid_o), 32'd0);
    check("bp release ready", 32'(ready_o), 32'd1);
    check("bp release result", result_o, 32'd15);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("bp second valid", 32'(valid_o), 32'd1);
    check("bp second result", result_o, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    check("bp second drop", 32'(valid_o), 32'd0);

    // Reset ten cycles into a DIVU.
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("midrst ready", 32'(ready_o), 32'd1);
    check("midrst valid", 32'(valid_o), 32'd0);
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst result", result_o, 32'd0);
    run_vec(vecs[18]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Iterative multiply/divide unit that extends the combinational integer ALU with the RV32M operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. Operand width is parametrised. Uses a valid/ready handshake on both input and output sides. Sits beside the main ALU in the execute stage; the core stalls while the block is busy.

Parameters:
XLEN, 32, operand and result width in bits; must be ≥ 4 and even.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  reset, synchronous and active-high
valid_i  input  1  request valid
ready_o  output  1  block can accept a request
op_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a_i  input  XLEN  operand A (multiplicand / dividend)
b_i  input  XLEN  operand B (multiplier / divisor)
valid_o  output  1  result valid
ready_i  input  1  consumer accepts result
result_o  output  XLEN  result
busy_o  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, counter=0. Reset has priority over all other inputs, including mid-CALC and mid-DONE; an in-flight operation is discarded.
- States:
  - IDLE: ready_o=1, busy_o=0.
  - CALC: ready_o=0, busy_o=1.
  - DONE: ready_o=0, valid_o=1, busy_o=1.
- Accept: valid_i && ready_o at edge t0. The block latches a_i, b_i and op_i. valid_i outside IDLE is ignored, and nothing is queued.
- Normal path: IDLE→CALC at t0. One radix-2 step per edge: shift-add for multiply, restoring subtract-shift for divide. After XLEN steps (edge t0+XLEN) the state goes CALC→DONE. valid_o rises in the cycle after edge t0+XLEN.
- Special cases go IDLE→DONE directly at t0, with valid_o high in the cycle after t0:
  - divisor 0: DIV/DIVU result = all ones; REM/REMU result = a.
  - DIV with a = signed minimum and b = −1: result = signed minimum (1 followed by XLEN−1 zeros).
  - REM with a = signed minimum and b = −1: result = 0.
- Sign handling: the iteration runs on magnitudes, and signs are applied when entering DONE.
  - MULH: a and b signed. MULHSU: a signed, b unsigned. MULHU and DIVU/REMU: both unsigned.
  - MUL: low XLEN bits of the 2·XLEN product; identical for signed and unsigned operands.
  - MULH*: high XLEN bits of the 2·XLEN product.
  - Quotient is negated when operand signs differ; division truncates toward zero.
  - Remainder takes the sign of the dividend.
- Output: result_o is registered and is stable whenever valid_o=1.
- DONE→IDLE: on valid_o && ready_i. valid_o falls the next cycle and result_o holds its last value. ready_i low keeps DONE indefinitely with result_o unchanged.
- No back-to-back overlap: a new request is accepted at the earliest in the cycle after the DONE→IDLE transition.
- Counter: width clog2(XLEN)+1; must not wrap before the XLEN-th step completes.

Test Plan:
All values use XLEN=32.
- MUL a=7, b=0xFFFFFFFD, accepted at t0 → valid_o=1 in cycle after t0+32, result_o=0xFFFFFFEB; ready_o=0 for cycles t0+1..t0+32.
- High multiply products:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - DIV 7/−2 → 0xFFFFFFFD.
  - REM 7/−2 → 1.
- Special cases, each with valid_o high in the cycle after the accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Backpressure: ready_i=0 for 5 cycles after valid_o rises, with valid_i=1 and new operands driven → valid_o and result_o held constant, ready_o=0, and the second request is not taken until after DONE→IDLE.
- Reset mid-operation: rst_i=1 for one edge, 10 cycles into a DIVU → next cycle ready_o=1, valid_o=0, busy_o=0, result_o=0. A following MUL 3×5 then returns 15 after the normal 32-cycle latency.
